// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: access widths,
// controller states and the default start of the IO address window.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2,
        W_RSVD = 2'd3
    } width_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_READ  = 2'd1,
        LS_READ  = 2'd2,
        LS_WRITE = 2'd3
    } state_e;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    // The reserved width code 3 moves a full word.
    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width)
            W_BYTE:  return 3'd1;
            W_HALF:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the controller, its two requesters and the byte-wide RAM/IO port.
interface mem_ctrl_if;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;

    logic        lsb_req;
    logic        lsb_we;
    logic [1:0]  lsb_width;
    logic        lsb_signed;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    modport slave (
        input  mem_din, if_req, if_addr,
        input  lsb_req, lsb_we, lsb_width, lsb_signed, lsb_addr, lsb_wdata,
        output mem_dout, mem_a, mem_wr, if_done, if_inst, lsb_done, lsb_rdata
    );

    modport master (
        output mem_din, if_req, if_addr,
        output lsb_req, lsb_we, lsb_width, lsb_signed, lsb_addr, lsb_wdata,
        input  mem_dout, mem_a, mem_wr, if_done, if_inst, lsb_done, lsb_rdata
    );

endinterface

// File: rtl/mem_ctrl_load_extend.sv
// Combinational load formatter: picks byte/half/word from four little-endian
// bytes and sign- or zero-extends the result to 32 bits.
module mem_load_extend
    import mem_ctrl_pkg::*;
(
    input  logic [3:0][7:0] bytes_in,
    input  logic [1:0]      width,
    input  logic            is_signed,
    output logic [31:0]     result
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_ext;
    logic signed [31:0] half_ext;

    always_comb begin
        byte_s   = bytes_in[0];
        half_s   = {bytes_in[1], bytes_in[0]};
        byte_ext = byte_s;
        half_ext = half_s;
        case (width)
            W_BYTE:  result = is_signed ? byte_ext : {24'd0, bytes_in[0]};
            W_HALF:  result = is_signed ? half_ext : {16'd0, bytes_in[1], bytes_in[0]};
            default: result = bytes_in;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO controller arbitrating the load/store buffer (priority)
// against instruction fetch, with IO store throttling on io_buffer_full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    input  logic       clear_flag,
    input  logic       io_buffer_full,
    mem_ctrl_if.slave  bus
);

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [31:0]     mem_a_q, mem_a_d;
    logic [7:0]      mem_dout_q, mem_dout_d;
    logic            mem_wr_q, mem_wr_d;
    logic            if_done_q, if_done_d;
    logic [31:0]     if_inst_q, if_inst_d;
    logic            lsb_done_q, lsb_done_d;
    logic [31:0]     lsb_rdata_q, lsb_rdata_d;

    logic [31:0]     addr_q, wdata_q;
    logic [1:0]      width_q;
    logic            signed_q, io_q;
    logic [2:0]      len_q;
    logic [3:0][7:0] buf_q;

    logic            latch_lsb, latch_if, cap_en;
    logic [2:0]      cap_idx;
    logic [3:0][7:0] asm_bytes;
    logic [31:0]     ext_data;

    // cnt_q counts edges since acceptance; byte k arrives on mem_din at edge k+2.
    assign cap_idx = cnt_q - 3'd2;

    always_comb begin
        asm_bytes = buf_q;
        if (cnt_q >= 3'd2) asm_bytes[cap_idx[1:0]] = bus.mem_din;
    end

    mem_load_extend u_load_extend (
        .bytes_in  (asm_bytes),
        .width     (width_q),
        .is_signed (signed_q),
        .result    (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        if_done_d   = 1'b0;
        if_inst_d   = if_inst_q;
        lsb_done_d  = 1'b0;
        lsb_rdata_d = lsb_rdata_q;
        latch_lsb   = 1'b0;
        latch_if    = 1'b0;
        cap_en      = 1'b0;

        case (state_q)
            IDLE: begin
                mem_wr_d = 1'b0;
                // A done pulse in flight forces a one-cycle bubble before the next grant.
                if (!if_done_q && !lsb_done_q) begin
                    if (bus.lsb_req) begin
                        latch_lsb = 1'b1;
                        mem_a_d   = bus.lsb_addr;
                        cnt_d     = 3'd1;
                        if (bus.lsb_we) begin
                            state_d = LS_WRITE;
                            if (bus.lsb_addr >= IO_BASE && io_buffer_full) begin
                                cnt_d = 3'd0;
                            end else begin
                                mem_dout_d = bus.lsb_wdata[7:0];
                                mem_wr_d   = 1'b1;
                            end
                        end else begin
                            state_d = LS_READ;
                        end
                    end else if (bus.if_req && !clear_flag) begin
                        latch_if = 1'b1;
                        state_d  = IF_READ;
                        mem_a_d  = bus.if_addr;
                        cnt_d    = 3'd1;
                    end
                end
            end

            IF_READ, LS_READ: begin
                if (state_q == IF_READ && clear_flag) begin
                    state_d  = IDLE;
                    cnt_d    = 3'd0;
                    mem_wr_d = 1'b0;
                end else begin
                    if (cnt_q < len_q) mem_a_d = addr_q + 32'(cnt_q);
                    cap_en = (cnt_q >= 3'd2);
                    if (cnt_q == len_q + 3'd1) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                        if (state_q == IF_READ) begin
                            if_done_d = 1'b1;
                            if_inst_d = ext_data;
                        end else begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = ext_data;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            LS_WRITE: begin
                // Here cnt_q is the index of the next byte to issue.
                if (cnt_q == len_q) begin
                    state_d     = IDLE;
                    cnt_d       = 3'd0;
                    mem_wr_d    = 1'b0;
                    lsb_done_d  = 1'b1;
                    lsb_rdata_d = 32'd0;
                end else if (io_q && io_buffer_full) begin
                    mem_wr_d = 1'b0;
                end else begin
                    mem_a_d    = addr_q + 32'(cnt_q);
                    mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    mem_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            mem_a_q     <= 32'd0;
            mem_dout_q  <= 8'd0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            if_inst_q   <= 32'd0;
            lsb_done_q  <= 1'b0;
            lsb_rdata_q <= 32'd0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_done_q   <= if_done_d;
            if_inst_q   <= if_inst_d;
            lsb_done_q  <= lsb_done_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    // Request fields and the byte buffer are only read after a grant reloads them.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (latch_lsb) begin
                addr_q   <= bus.lsb_addr;
                wdata_q  <= bus.lsb_wdata;
                width_q  <= bus.lsb_width;
                signed_q <= bus.lsb_signed;
                len_q    <= byte_count(bus.lsb_width);
                io_q     <= (bus.lsb_addr >= IO_BASE);
            end else if (latch_if) begin
                addr_q   <= bus.if_addr;
                wdata_q  <= 32'd0;
                width_q  <= W_WORD;
                signed_q <= 1'b0;
                len_q    <= 3'd4;
                io_q     <= 1'b0;
            end
            if (cap_en) buf_q[cap_idx[1:0]] <= bus.mem_din;
        end
    end

    assign bus.mem_a     = mem_a_q;
    assign bus.mem_dout  = mem_dout_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.lsb_done  = lsb_done_q;
    assign bus.lsb_rdata = lsb_rdata_q;

endmodule
